// File: rtl/diff_commit_stage.sv
// diff_commit_stage
//
// Final stage ahead of the differential-testing reference model. It
// registers up to three retiring instructions per cycle, an exception
// report and a store stream, and presents them in the widened layout the
// reference-model comparator consumes.
//
// Ports
//   clock, reset          single clock, asynchronous active-high reset
//   in_*_k   (k=0..2)     retire slots, slot 0 oldest: valid, pc, instr,
//                         GPR writeback (wen/wdest/wdata), skip
//   in_excp_*, in_eret    exception / eret report for this cycle
//   in_st_*_j (j=0..1)    retired stores, port 0 older
//   out_*_k  (k=0..2)     compacted commit lanes, one cycle after sampling
//   out_excp_*, out_eret  registered exception report
//   out_st_*              head of the store queue (combinational view)
//   st_overflow           sticky: a store was dropped for lack of space
//   commit_cnt            running total of retired instructions (mod 2^64)
//
// Flow control: there is no back-pressure anywhere. A retire slot or store
// port is consumed on the rising edge where its valid is 1. The store queue
// drains one entry per cycle unconditionally; its head is shown on out_st_*
// for exactly the cycle before it is removed.

module diff_commit_stage #(
  parameter int STQ_DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid_0,
  input  logic [31:0] in_pc_0,
  input  logic [31:0] in_instr_0,
  input  logic        in_wen_0,
  input  logic [4:0]  in_wdest_0,
  input  logic [31:0] in_wdata_0,
  input  logic        in_skip_0,
  input  logic        in_valid_1,
  input  logic [31:0] in_pc_1,
  input  logic [31:0] in_instr_1,
  input  logic        in_wen_1,
  input  logic [4:0]  in_wdest_1,
  input  logic [31:0] in_wdata_1,
  input  logic        in_skip_1,
  input  logic        in_valid_2,
  input  logic [31:0] in_pc_2,
  input  logic [31:0] in_instr_2,
  input  logic        in_wen_2,
  input  logic [4:0]  in_wdest_2,
  input  logic [31:0] in_wdata_2,
  input  logic        in_skip_2,
  input  logic        in_excp_valid,
  input  logic        in_eret,
  input  logic [5:0]  in_ecode,
  input  logic [31:0] in_excp_pc,
  input  logic [31:0] in_excp_inst,
  input  logic        in_st_valid_0,
  input  logic [7:0]  in_st_mask_0,
  input  logic [31:0] in_st_paddr_0,
  input  logic [31:0] in_st_vaddr_0,
  input  logic [31:0] in_st_data_0,
  input  logic        in_st_valid_1,
  input  logic [7:0]  in_st_mask_1,
  input  logic [31:0] in_st_paddr_1,
  input  logic [31:0] in_st_vaddr_1,
  input  logic [31:0] in_st_data_1,
  output logic        out_valid_0,
  output logic [7:0]  out_index_0,
  output logic [63:0] out_pc_0,
  output logic [31:0] out_instr_0,
  output logic        out_skip_0,
  output logic        out_wen_0,
  output logic [7:0]  out_wdest_0,
  output logic [63:0] out_wdata_0,
  output logic        out_valid_1,
  output logic [7:0]  out_index_1,
  output logic [63:0] out_pc_1,
  output logic [31:0] out_instr_1,
  output logic        out_skip_1,
  output logic        out_wen_1,
  output logic [7:0]  out_wdest_1,
  output logic [63:0] out_wdata_1,
  output logic        out_valid_2,
  output logic [7:0]  out_index_2,
  output logic [63:0] out_pc_2,
  output logic [31:0] out_instr_2,
  output logic        out_skip_2,
  output logic        out_wen_2,
  output logic [7:0]  out_wdest_2,
  output logic [63:0] out_wdata_2,
  output logic        out_excp_valid,
  output logic        out_eret,
  output logic [5:0]  out_cause,
  output logic [31:0] out_excp_pc,
  output logic [31:0] out_excp_inst,
  output logic [7:0]  out_st_valid,
  output logic [7:0]  out_st_index,
  output logic [63:0] out_st_paddr,
  output logic [63:0] out_st_vaddr,
  output logic [63:0] out_st_data,
  output logic        st_overflow,
  output logic [63:0] commit_cnt
);

  localparam int PTR_W = $clog2(STQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // ---------------------------------------------------------------- slots
  logic        s_valid [3];
  logic [31:0] s_pc    [3];
  logic [31:0] s_instr [3];
  logic        s_wen   [3];
  logic [4:0]  s_wdest [3];
  logic [31:0] s_wdata [3];
  logic        s_skip  [3];

  assign s_valid[0] = in_valid_0;  assign s_valid[1] = in_valid_1;  assign s_valid[2] = in_valid_2;
  assign s_pc[0]    = in_pc_0;     assign s_pc[1]    = in_pc_1;     assign s_pc[2]    = in_pc_2;
  assign s_instr[0] = in_instr_0;  assign s_instr[1] = in_instr_1;  assign s_instr[2] = in_instr_2;
  assign s_wen[0]   = in_wen_0;    assign s_wen[1]   = in_wen_1;    assign s_wen[2]   = in_wen_2;
  assign s_wdest[0] = in_wdest_0;  assign s_wdest[1] = in_wdest_1;  assign s_wdest[2] = in_wdest_2;
  assign s_wdata[0] = in_wdata_0;  assign s_wdata[1] = in_wdata_1;  assign s_wdata[2] = in_wdata_2;
  assign s_skip[0]  = in_skip_0;   assign s_skip[1]  = in_skip_1;   assign s_skip[2]  = in_skip_2;

  // ----------------------------------------------------------- compaction
  logic [1:0] n_retire;
  logic [1:0] src      [3];
  logic       lane_v   [3];
  logic       lane_wen [3];

  assign n_retire = {1'b0, in_valid_0} + {1'b0, in_valid_1} + {1'b0, in_valid_2};

  // Lane l takes the (l+1)-th valid slot in slot order. Lane 1 can only
  // come from slot 1 when slots 0 and 1 are both valid; otherwise the
  // second valid slot is necessarily slot 2. Lane 2 exists only when all
  // three slots are valid.
  always_comb begin
    lane_v[0] = in_valid_0 | in_valid_1 | in_valid_2;
    src[0]    = in_valid_0 ? 2'd0 : (in_valid_1 ? 2'd1 : 2'd2);
    lane_v[1] = (n_retire >= 2'd2);
    src[1]    = (in_valid_0 && in_valid_1) ? 2'd1 : 2'd2;
    lane_v[2] = (n_retire == 2'd3);
    src[2]    = 2'd2;
    for (int l = 0; l < 3; l++) begin
      // r0 is hardwired zero: a write to it is not a real writeback.
      lane_wen[l] = lane_v[l] && s_wen[src[l]] && (s_wdest[src[l]] != 5'd0);
    end
  end

  // --------------------------------------------------------- lane registers
  logic        r_valid [3];
  logic [31:0] r_pc    [3];
  logic [31:0] r_instr [3];
  logic        r_skip  [3];
  logic        r_wen   [3];
  logic [4:0]  r_wdest [3];
  logic [31:0] r_wdata [3];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int l = 0; l < 3; l++) begin
        r_valid[l] <= 1'b0;
        r_pc[l]    <= '0;
        r_instr[l] <= '0;
        r_skip[l]  <= 1'b0;
        r_wen[l]   <= 1'b0;
        r_wdest[l] <= '0;
        r_wdata[l] <= '0;
      end
      commit_cnt <= '0;
    end else begin
      for (int l = 0; l < 3; l++) begin
        r_valid[l] <= lane_v[l];
        r_pc[l]    <= lane_v[l] ? s_pc[src[l]]    : '0;
        r_instr[l] <= lane_v[l] ? s_instr[src[l]] : '0;
        r_skip[l]  <= lane_v[l] ? s_skip[src[l]]  : 1'b0;
        r_wen[l]   <= lane_wen[l];
        r_wdest[l] <= lane_v[l] ? s_wdest[src[l]] : '0;
        r_wdata[l] <= lane_wen[l] ? s_wdata[src[l]] : '0;
      end
      commit_cnt <= commit_cnt + {62'd0, n_retire};
    end
  end

  assign out_valid_0 = r_valid[0];
  assign out_index_0 = 8'd0;
  assign out_pc_0    = {32'd0, r_pc[0]};
  assign out_instr_0 = r_instr[0];
  assign out_skip_0  = r_skip[0];
  assign out_wen_0   = r_wen[0];
  assign out_wdest_0 = {3'd0, r_wdest[0]};
  assign out_wdata_0 = {32'd0, r_wdata[0]};

  assign out_valid_1 = r_valid[1];
  assign out_index_1 = r_valid[1] ? 8'd1 : 8'd0;
  assign out_pc_1    = {32'd0, r_pc[1]};
  assign out_instr_1 = r_instr[1];
  assign out_skip_1  = r_skip[1];
  assign out_wen_1   = r_wen[1];
  assign out_wdest_1 = {3'd0, r_wdest[1]};
  assign out_wdata_1 = {32'd0, r_wdata[1]};

  assign out_valid_2 = r_valid[2];
  assign out_index_2 = r_valid[2] ? 8'd2 : 8'd0;
  assign out_pc_2    = {32'd0, r_pc[2]};
  assign out_instr_2 = r_instr[2];
  assign out_skip_2  = r_skip[2];
  assign out_wen_2   = r_wen[2];
  assign out_wdest_2 = {3'd0, r_wdest[2]};
  assign out_wdata_2 = {32'd0, r_wdata[2]};

  // ------------------------------------------------------------ exception
  // eret is reported independently of the exception valid bit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_excp_valid <= 1'b0;
      out_eret       <= 1'b0;
      out_cause      <= '0;
      out_excp_pc    <= '0;
      out_excp_inst  <= '0;
    end else begin
      out_excp_valid <= in_excp_valid;
      out_eret       <= in_eret;
      out_cause      <= in_excp_valid ? in_ecode     : '0;
      out_excp_pc    <= in_excp_valid ? in_excp_pc   : '0;
      out_excp_inst  <= in_excp_valid ? in_excp_inst : '0;
    end
  end

  // ---------------------------------------------------------- store queue
  logic [7:0]       q_mask  [STQ_DEPTH];
  logic [31:0]      q_paddr [STQ_DEPTH];
  logic [31:0]      q_vaddr [STQ_DEPTH];
  logic [31:0]      q_data  [STQ_DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] tail_p1;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] free_slots;
  logic [CNT_W-1:0] count_nxt;
  logic [7:0]       st_seq;
  logic             pop;
  logic             req_0;
  logic             req_1;
  logic             acc_0;
  logic             acc_1;
  logic             drop;

  assign pop   = (count != '0);
  assign req_0 = in_st_valid_0 && (in_st_mask_0 != 8'd0);
  assign req_1 = in_st_valid_1 && (in_st_mask_1 != 8'd0);

  // The head leaves on the same edge the new stores arrive, so its slot
  // already counts as free.
  assign free_slots = CNT_W'(STQ_DEPTH) - count + {{(CNT_W-1){1'b0}}, pop};

  // Port 0 is older, so when space is short port 1 loses first.
  assign acc_0 = req_0 && (free_slots != '0);
  assign acc_1 = req_1 && (acc_0 ? (free_slots >= CNT_W'(2)) : (free_slots != '0));
  assign drop  = (req_0 && !acc_0) || (req_1 && !acc_1);

  assign tail_p1   = tail + {{(PTR_W-1){1'b0}}, acc_0};
  assign count_nxt = count - {{(CNT_W-1){1'b0}}, pop}
                           + {{(CNT_W-1){1'b0}}, acc_0}
                           + {{(CNT_W-1){1'b0}}, acc_1};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      st_seq      <= '0;
      st_overflow <= 1'b0;
    end else begin
      head        <= head + {{(PTR_W-1){1'b0}}, pop};
      tail        <= tail_p1 + {{(PTR_W-1){1'b0}}, acc_1};
      count       <= count_nxt;
      st_seq      <= st_seq + {7'd0, pop};
      st_overflow <= st_overflow | drop;
    end
  end

  // Entry storage needs no reset: count gates every read of it.
  always_ff @(posedge clock) begin
    if (acc_0) begin
      q_mask[tail]  <= in_st_mask_0;
      q_paddr[tail] <= in_st_paddr_0;
      q_vaddr[tail] <= in_st_vaddr_0;
      q_data[tail]  <= in_st_data_0;
    end
    if (acc_1) begin
      q_mask[tail_p1]  <= in_st_mask_1;
      q_paddr[tail_p1] <= in_st_paddr_1;
      q_vaddr[tail_p1] <= in_st_vaddr_1;
      q_data[tail_p1]  <= in_st_data_1;
    end
  end

  assign out_st_valid = pop ? q_mask[head] : 8'd0;
  assign out_st_index = pop ? st_seq : 8'd0;
  assign out_st_paddr = pop ? {32'd0, q_paddr[head]} : 64'd0;
  assign out_st_vaddr = pop ? {32'd0, q_vaddr[head]} : 64'd0;
  assign out_st_data  = pop ? {32'd0, q_data[head]}  : 64'd0;

endmodule

// File: tb/tb_diff_commit_stage.sv
module tb_diff_commit_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid_0, in_valid_1, in_valid_2;
  logic [31:0] in_pc_0, in_pc_1, in_pc_2;
  logic [31:0] in_instr_0, in_instr_1, in_instr_2;
  logic        in_wen_0, in_wen_1, in_wen_2;
  logic [4:0]  in_wdest_0, in_wdest_1, in_wdest_2;
  logic [31:0] in_wdata_0, in_wdata_1, in_wdata_2;
  logic        in_skip_0, in_skip_1, in_skip_2;
  logic        in_excp_valid, in_eret;
  logic [5:0]  in_ecode;
  logic [31:0] in_excp_pc, in_excp_inst;
  logic        in_st_valid_0, in_st_valid_1;
  logic [7:0]  in_st_mask_0, in_st_mask_1;
  logic [31:0] in_st_paddr_0, in_st_vaddr_0, in_st_data_0;
  logic [31:0] in_st_paddr_1, in_st_vaddr_1, in_st_data_1;

  logic        out_valid_0, out_valid_1, out_valid_2;
  logic [7:0]  out_index_0, out_index_1, out_index_2;
  logic [63:0] out_pc_0, out_pc_1, out_pc_2;
  logic [31:0] out_instr_0, out_instr_1, out_instr_2;
  logic        out_skip_0, out_skip_1, out_skip_2;
  logic        out_wen_0, out_wen_1, out_wen_2;
  logic [7:0]  out_wdest_0, out_wdest_1, out_wdest_2;
  logic [63:0] out_wdata_0, out_wdata_1, out_wdata_2;
  logic        out_excp_valid, out_eret;
  logic [5:0]  out_cause;
  logic [31:0] out_excp_pc, out_excp_inst;
  logic [7:0]  out_st_valid, out_st_index;
  logic [63:0] out_st_paddr, out_st_vaddr, out_st_data;
  logic        st_overflow;
  logic [63:0] commit_cnt;

  int checks = 0;
  int passed = 0;

  diff_commit_stage #(.STQ_DEPTH(4)) dut (
    .clock(clock), .reset(reset),
    .in_valid_0(in_valid_0), .in_pc_0(in_pc_0), .in_instr_0(in_instr_0),
    .in_wen_0(in_wen_0), .in_wdest_0(in_wdest_0), .in_wdata_0(in_wdata_0), .in_skip_0(in_skip_0),
    .in_valid_1(in_valid_1), .in_pc_1(in_pc_1), .in_instr_1(in_instr_1),
    .in_wen_1(in_wen_1), .in_wdest_1(in_wdest_1), .in_wdata_1(in_wdata_1), .in_skip_1(in_skip_1),
    .in_valid_2(in_valid_2), .in_pc_2(in_pc_2), .in_instr_2(in_instr_2),
    .in_wen_2(in_wen_2), .in_wdest_2(in_wdest_2), .in_wdata_2(in_wdata_2), .in_skip_2(in_skip_2),
    .in_excp_valid(in_excp_valid), .in_eret(in_eret), .in_ecode(in_ecode),
    .in_excp_pc(in_excp_pc), .in_excp_inst(in_excp_inst),
    .in_st_valid_0(in_st_valid_0), .in_st_mask_0(in_st_mask_0), .in_st_paddr_0(in_st_paddr_0),
    .in_st_vaddr_0(in_st_vaddr_0), .in_st_data_0(in_st_data_0),
    .in_st_valid_1(in_st_valid_1), .in_st_mask_1(in_st_mask_1), .in_st_paddr_1(in_st_paddr_1),
    .in_st_vaddr_1(in_st_vaddr_1), .in_st_data_1(in_st_data_1),
    .out_valid_0(out_valid_0), .out_index_0(out_index_0), .out_pc_0(out_pc_0), .out_instr_0(out_instr_0),
    .out_skip_0(out_skip_0), .out_wen_0(out_wen_0), .out_wdest_0(out_wdest_0), .out_wdata_0(out_wdata_0),
    .out_valid_1(out_valid_1), .out_index_1(out_index_1), .out_pc_1(out_pc_1), .out_instr_1(out_instr_1),
    .out_skip_1(out_skip_1), .out_wen_1(out_wen_1), .out_wdest_1(out_wdest_1), .out_wdata_1(out_wdata_1),
    .out_valid_2(out_valid_2), .out_index_2(out_index_2), .out_pc_2(out_pc_2), .out_instr_2(out_instr_2),
    .out_skip_2(out_skip_2), .out_wen_2(out_wen_2), .out_wdest_2(out_wdest_2), .out_wdata_2(out_wdata_2),
    .out_excp_valid(out_excp_valid), .out_eret(out_eret), .out_cause(out_cause),
    .out_excp_pc(out_excp_pc), .out_excp_inst(out_excp_inst),
    .out_st_valid(out_st_valid), .out_st_index(out_st_index), .out_st_paddr(out_st_paddr),
    .out_st_vaddr(out_st_vaddr), .out_st_data(out_st_data),
    .st_overflow(st_overflow), .commit_cnt(commit_cnt)
  );

  // ---------------------------------------------------------- clock/reset
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // -------------------------------------------------------------- drivers
  task automatic drive_idle();
    in_valid_0 = 0; in_valid_1 = 0; in_valid_2 = 0;
    in_pc_0 = 0; in_pc_1 = 0; in_pc_2 = 0;
    in_instr_0 = 0; in_instr_1 = 0; in_instr_2 = 0;
    in_wen_0 = 0; in_wen_1 = 0; in_wen_2 = 0;
    in_wdest_0 = 0; in_wdest_1 = 0; in_wdest_2 = 0;
    in_wdata_0 = 0; in_wdata_1 = 0; in_wdata_2 = 0;
    in_skip_0 = 0; in_skip_1 = 0; in_skip_2 = 0;
    in_excp_valid = 0; in_eret = 0; in_ecode = 0; in_excp_pc = 0; in_excp_inst = 0;
    in_st_valid_0 = 0; in_st_mask_0 = 0; in_st_paddr_0 = 0; in_st_vaddr_0 = 0; in_st_data_0 = 0;
    in_st_valid_1 = 0; in_st_mask_1 = 0; in_st_paddr_1 = 0; in_st_vaddr_1 = 0; in_st_data_1 = 0;
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_st0(input logic [7:0] mask, input logic [31:0] data);
    in_st_valid_0 = 1; in_st_mask_0 = mask;
    in_st_paddr_0 = data ^ 32'h0000_1000; in_st_vaddr_0 = data ^ 32'h0000_2000; in_st_data_0 = data;
  endtask

  task automatic drive_st1(input logic [7:0] mask, input logic [31:0] data);
    in_st_valid_1 = 1; in_st_mask_1 = mask;
    in_st_paddr_1 = data ^ 32'h0000_1000; in_st_vaddr_1 = data ^ 32'h0000_2000; in_st_data_1 = data;
  endtask

  // ----------------------------------------------------------- scoreboard
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  logic [31:0] exp_q[$];
  logic [7:0]  exp_idx;
  logic [31:0] d;

  // ------------------------------------------------------------- sequence
  initial begin
    drive_idle();
    reset = 1;
    tick();
    tick();
    chk("rst_valid0", 64'(out_valid_0), 64'd0);
    chk("rst_pc0", out_pc_0, 64'd0);
    chk("rst_commit_cnt", commit_cnt, 64'd0);
    chk("rst_st_valid", 64'(out_st_valid), 64'd0);
    chk("rst_overflow", 64'(st_overflow), 64'd0);
    chk("rst_excp", 64'(out_excp_valid), 64'd0);
    reset = 0;

    // First edge after release: slots {0,1,1} compacted into lanes 0,1.
    in_valid_1 = 1; in_pc_1 = 32'h1C00_0010; in_instr_1 = 32'h0280_0400;
    in_valid_2 = 1; in_pc_2 = 32'h1C00_0014; in_instr_2 = 32'h0280_0800; in_skip_2 = 1;
    tick();
    chk("cmp_v0", 64'(out_valid_0), 64'd1);
    chk("cmp_pc0", out_pc_0, 64'h0000_0000_1C00_0010);
    chk("cmp_idx0", 64'(out_index_0), 64'd0);
    chk("cmp_instr0", 64'(out_instr_0), 64'h0280_0400);
    chk("cmp_skip0", 64'(out_skip_0), 64'd0);
    chk("cmp_v1", 64'(out_valid_1), 64'd1);
    chk("cmp_pc1", out_pc_1, 64'h0000_0000_1C00_0014);
    chk("cmp_idx1", 64'(out_index_1), 64'd1);
    chk("cmp_skip1", 64'(out_skip_1), 64'd1);
    chk("cmp_v2", 64'(out_valid_2), 64'd0);
    chk("cmp_pc2", out_pc_2, 64'd0);
    chk("cmp_idx2", 64'(out_index_2), 64'd0);
    chk("cmp_cnt", commit_cnt, 64'd2);

    // Write to r0 is suppressed; eret passes without exception valid.
    drive_idle();
    in_valid_0 = 1; in_pc_0 = 32'h1C00_0018; in_wen_0 = 1; in_wdest_0 = 5'd0; in_wdata_0 = 32'hDEAD;
    in_eret = 1; in_ecode = 6'h3F; in_excp_pc = 32'h1234_5678;
    tick();
    chk("r0_wen", 64'(out_wen_0), 64'd0);
    chk("r0_wdata", out_wdata_0, 64'd0);
    chk("r0_v1", 64'(out_valid_1), 64'd0);
    chk("eret_pass", 64'(out_eret), 64'd1);
    chk("eret_cause", 64'(out_cause), 64'd0);
    chk("eret_pc", 64'(out_excp_pc), 64'd0);
    chk("r0_cnt", commit_cnt, 64'd3);

    // Real writeback, all three slots valid, exception reported.
    drive_idle();
    in_valid_0 = 1; in_pc_0 = 32'h1C00_001C; in_wen_0 = 1; in_wdest_0 = 5'd5; in_wdata_0 = 32'hDEAD;
    in_valid_1 = 1; in_pc_1 = 32'h1C00_0020; in_wen_1 = 0; in_wdest_1 = 5'd7; in_wdata_1 = 32'hBEEF;
    in_valid_2 = 1; in_pc_2 = 32'h1C00_0024; in_wen_2 = 1; in_wdest_2 = 5'd31; in_wdata_2 = 32'hFFFF_FFFF;
    in_excp_valid = 1; in_ecode = 6'h0D; in_excp_pc = 32'h1C00_0100; in_excp_inst = 32'h0020_0000;
    tick();
    chk("wb_wen0", 64'(out_wen_0), 64'd1);
    chk("wb_wdata0", out_wdata_0, 64'h0000_0000_0000_DEAD);
    chk("wb_wdest0", 64'(out_wdest_0), 64'd5);
    chk("wb_wen1", 64'(out_wen_1), 64'd0);
    chk("wb_wdata1", out_wdata_1, 64'd0);
    chk("wb_wdata2", out_wdata_2, 64'h0000_0000_FFFF_FFFF);
    chk("wb_pc2", out_pc_2, 64'h0000_0000_1C00_0024);
    chk("wb_idx2", 64'(out_index_2), 64'd2);
    chk("excp_valid", 64'(out_excp_valid), 64'd1);
    chk("excp_cause", 64'(out_cause), 64'h0D);
    chk("excp_pc", 64'(out_excp_pc), 64'h1C00_0100);
    chk("excp_inst", 64'(out_excp_inst), 64'h0020_0000);
    chk("wb_cnt", commit_cnt, 64'd6);

    drive_idle();
    tick();
    chk("idle_v0", 64'(out_valid_0), 64'd0);
    chk("idle_excp", 64'(out_excp_valid), 64'd0);
    chk("idle_cnt", commit_cnt, 64'd6);
    chk("idle_st", 64'(out_st_valid), 64'd0);

    // Single store into an empty queue: visible for exactly one cycle.
    drive_st0(8'h0F, 32'h1111_1111);
    tick();
    chk("st1_valid", 64'(out_st_valid), 64'h0F);
    chk("st1_idx", 64'(out_st_index), 64'd0);
    chk("st1_data", out_st_data, 64'h0000_0000_1111_1111);
    chk("st1_paddr", out_st_paddr, 64'h0000_0000_1111_0111);
    chk("st1_vaddr", out_st_vaddr, 64'h0000_0000_1111_3111);
    drive_idle();
    tick();
    chk("st1_gone", 64'(out_st_valid), 64'd0);
    chk("st1_gone_idx", 64'(out_st_index), 64'd0);

    // Zero-mask store is not queued.
    drive_st0(8'h00, 32'h2222_2222);
    tick();
    drive_idle();
    chk("mask0_none", 64'(out_st_valid), 64'd0);

    // Both ports for four cycles: queue fills; port 1 drops on the 4th edge.
    exp_idx = 8'd1;
    for (int k = 1; k <= 4; k++) begin
      drive_st0(8'h0F, 32'hA000_0000 + 32'(k));
      drive_st1(8'h0F, 32'hB000_0000 + 32'(k));
      exp_q.push_back(32'hA000_0000 + 32'(k));
      if (k < 4) exp_q.push_back(32'hB000_0000 + 32'(k));
      tick();
      d = exp_q.pop_front();
      chk("fill_data", out_st_data, {32'd0, d});
      chk("fill_idx", 64'(out_st_index), 64'(exp_idx));
      chk("fill_ovf", 64'(st_overflow), (k == 4) ? 64'd1 : 64'd0);
      exp_idx++;
    end
    drive_idle();
    while (exp_q.size() != 0) begin
      tick();
      d = exp_q.pop_front();
      chk("drain_data", out_st_data, {32'd0, d});
      chk("drain_valid", 64'(out_st_valid), 64'h0F);
      chk("drain_idx", 64'(out_st_index), 64'(exp_idx));
      exp_idx++;
    end
    tick();
    chk("drain_empty", 64'(out_st_valid), 64'd0);
    chk("ovf_sticky", 64'(st_overflow), 64'd1);

    // commit_cnt wrap: preload all-ones, then retire three.
    force dut.commit_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    in_valid_0 = 1; in_valid_1 = 1; in_valid_2 = 1;
    #1;
    release dut.commit_cnt;
    tick();
    chk("wrap_cnt", commit_cnt, 64'd2);
    drive_idle();

    // Reset mid-stream with three stores queued.
    drive_st0(8'h0F, 32'hC000_0001);
    drive_st1(8'h0F, 32'hC000_0002);
    tick();
    drive_idle();
    drive_st0(8'h0F, 32'hC000_0003);
    drive_st1(8'h0F, 32'hC000_0004);
    in_valid_0 = 1;
    tick();
    drive_idle();
    chk("pre_rst_st", 64'(out_st_valid), 64'h0F);
    reset = 1;
    #1;
    chk("rst_mid_st", 64'(out_st_valid), 64'd0);
    chk("rst_mid_ovf", 64'(st_overflow), 64'd0);
    chk("rst_mid_cnt", commit_cnt, 64'd0);
    chk("rst_mid_v0", 64'(out_valid_0), 64'd0);
    tick();
    reset = 0;
    in_valid_0 = 1; in_pc_0 = 32'h1C00_0200;
    tick();
    drive_idle();
    chk("post_rst_st", 64'(out_st_valid), 64'd0);
    chk("post_rst_v0", 64'(out_valid_0), 64'd1);
    chk("post_rst_pc0", out_pc_0, 64'h0000_0000_1C00_0200);
    chk("post_rst_cnt", commit_cnt, 64'd1);
    tick();
    chk("post_rst_st2", 64'(out_st_valid), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
